// File: rtl/button_toggle_bank.sv
// Multi-channel debounced push-button controller with toggle/momentary LED drive.
// Optional long-press detection is compiled in with `define BTN_LONG_PRESS_EN.

module button_toggle_chan #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic mode,
  output logic led,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_chk
    $error("button_toggle_chan: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  logic          s1, s2, stb, stb_d;
  logic [CW-1:0] cnt;
  logic          long_hit;

  // cnt is cleared on accept, so it can never pass CNT_LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      stb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == stb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_d         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      led           <= 1'b0;
    end else begin
      stb_d         <= stb;
      press_pulse   <= stb & ~stb_d;
      release_pulse <= ~stb & stb_d;
      if (mode)
        led <= stb;
      else if (long_hit)
        led <= 1'b0;
      else if (stb & ~stb_d)
        led <= ~led;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int            LW        = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lcnt;

  // Counter parks at LONG_MAX so the strobe fires only once per press
  assign long_hit = stb && (lcnt == LONG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= long_hit;
      if (!stb)
        lcnt <= '0;
      else if (lcnt != LONG_MAX)
        lcnt <= lcnt + 1'b1;
    end
  end
`else
  assign long_hit   = 1'b0;
  assign long_pulse = 1'b0;
`endif

endmodule

module button_toggle_bank #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] mode,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);
  if (N_CH < 1) begin : g_param_chk
    $error("button_toggle_bank: N_CH must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_toggle_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn[i]),
      .mode         (mode[i]),
      .led          (led[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_toggle_bank.sv
// Scoreboard bench for button_toggle_bank: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever any pulse output is high.

module tb_button_toggle_bank;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn, mode, led, press_pulse, release_pulse, long_pulse;

  button_toggle_bank #(
    .N_CH(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .mode(mode), .led(led),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pr, rl, lg, ld;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] pr, rl, lg, ld);
    exp_t x;
    x.cyc = c; x.pr = pr; x.rl = rl; x.lg = lg; x.ld = ld;
    q.push_back(x);
  endtask

  // Monitor: every visible pulse must match the next expected event
  always @(negedge clk) begin
    if (rst_n && (press_pulse | release_pulse | long_pulse) != 4'h0) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_pulse: got press=%b release=%b long=%b, none expected (cycle %0d)",
                 press_pulse, release_pulse, long_pulse, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("press_pulse", press_pulse, e.pr);
        chk("release_pulse", release_pulse, e.rl);
        chk("long_pulse", long_pulse, e.lg);
        chk("led_at_pulse", led, e.ld);
      end
    end
  end

  initial begin
    btn   = 4'h0;
    mode  = 4'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_long", long_pulse, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef BTN_LONG_PRESS_EN
    // Long press: toggle on, long strobe 8 after stb rises forces led off
    btn[0] = 1'b1;
    push(cyc + 7,  4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push(cyc + 14, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    repeat (30) @(negedge clk);
    btn[0] = 1'b0;
    push(cyc + 7,  4'b0000, 4'b0001, 4'b0000, 4'b0000);
    repeat (10) @(negedge clk);
`endif

    // Toggle: two press/release cycles on ch0
    btn[0] = 1'b1;
    push(cyc + 7, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    repeat (10) @(negedge clk);
    btn[0] = 1'b0;
    push(cyc + 7, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    repeat (10) @(negedge clk);
    btn[0] = 1'b1;
    push(cyc + 7, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    repeat (10) @(negedge clk);
    btn[0] = 1'b0;
    push(cyc + 7, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    repeat (10) @(negedge clk);

    // Glitch: 3 high / 1 low never accepted, then a 4-cycle high is
    for (int k = 0; k < 3; k++) begin
      btn[1] = 1'b1;
      repeat (3) @(negedge clk);
      btn[1] = 1'b0;
      @(negedge clk);
    end
    chk("glitch_led1", led[1], 0);
    btn[1] = 1'b1;
    push(cyc + 7, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    repeat (4) @(negedge clk);
    btn[1] = 1'b0;
    push(cyc + 7, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    repeat (10) @(negedge clk);

    // Momentary on ch2, held 20 cycles
    mode = 4'b0100;
    @(negedge clk);
    btn[2] = 1'b1;
    push(cyc + 7, 4'b0100, 4'b0000, 4'b0000, 4'b0110);
    repeat (10) @(negedge clk);
    chk("mom_mid_led2", led[2], 1);
    repeat (10) @(negedge clk);
    btn[2] = 1'b0;
    push(cyc + 7, 4'b0000, 4'b0100, 4'b0000, 4'b0010);
    repeat (6) @(negedge clk);
    chk("mom_hold_led2", led[2], 1);
    repeat (4) @(negedge clk);

    // Simultaneous ch0 + ch3, ch1 idle
    btn = 4'b1001;
    push(cyc + 7, 4'b1001, 4'b0000, 4'b0000, 4'b1011);
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    push(cyc + 7, 4'b0000, 4'b1001, 4'b0000, 4'b1011);
    repeat (10) @(negedge clk);

    // Async reset mid-debounce, buttons held across release
    btn = 4'hF;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_press", press_pulse, 0);
    chk("async_rst_release", release_pulse, 0);
    chk("async_rst_long", long_pulse, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(cyc + 7, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    repeat (10) @(negedge clk);
    btn = 4'h0;
    push(cyc + 7, 4'b0000, 4'b1111, 4'b0000, 4'b1011);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/button_toggle_bank.md
# button_toggle_bank

Multi-channel debounced push-button controller: synchronises N asynchronous button inputs, debounces each with a counter, and drives one LED per channel in either toggle or momentary mode. It emits single-cycle press and release pulses for downstream logic. The block sits between board buttons and the LED/user-logic fabric.

## Interface
- `N_CH`, default 4: number of independent button/LED channels (≥1).
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (≥2); 10 ms at 100 MHz.
- `LONG_CYCLES`, default 100000000: stable-pressed cycles for a long press (≥2). Used only with `BTN_LONG_PRESS_EN`.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn` input N_CH: raw asynchronous buttons, active-high.
- `mode` input N_CH: per channel, 0 = toggle, 1 = momentary; synchronous, sampled every cycle.
- `led` output N_CH: LED drive.
- `press_pulse` output N_CH: one-cycle strobe on accepted press.
- `release_pulse` output N_CH: one-cycle strobe on accepted release.
- `long_pulse` output N_CH: one-cycle strobe on long press; constant 0 without the macro.

## Operation
- Per channel: 2-FF synchroniser (`s1`, `s2`) -> debouncer (`cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, holds debounced state `stb`) -> edge detect -> LED register.
- Debouncer:
  - If `s2 == stb`, `cnt` is 0.
  - Otherwise `cnt` increments. On the edge where `cnt == DEBOUNCE_CYCLES-1` and the mismatch persists, `stb <= s2` and `cnt <= 0`.
  - Any return to `s2 == stb` before that edge clears `cnt`. Glitches shorter than `DEBOUNCE_CYCLES` never change `stb`.
- Edge detect uses registered `stb_d`:
  - `press_pulse = stb & ~stb_d`.
  - `release_pulse = ~stb & stb_d`.
  - Both are registered outputs, high for exactly 1 cycle.
- LED, updated on the same edge as the pulses:
  - `mode` = 0: `led` inverts on each accepted press and is unchanged on release.
  - `mode` = 1: `led` follows `stb`.
  - A `mode` change takes effect on the next edge. Switching 1 -> 0 keeps the current `led` value.
- Channels are fully independent. Simultaneous presses on any subset all act in the same cycle.
- Reset (async assert, any time including mid-debounce): `s1`, `s2`, `stb`, `stb_d`, `cnt`, long counter, `led`, and all pulses go to 0 immediately.
  - A button held across reset release is a new press and is accepted after the full debounce latency.

## Timing
- Edge 0 is the first edge sampling `btn` = 1 and also the first edge of sync stage 1. `s2` = 1 after edge 1.
- `stb` rises at edge `DEBOUNCE_CYCLES+1`. `press_pulse` and `led` change at edge `DEBOUNCE_CYCLES+2`.
- Release follows the same latency. No combinational path from input to output.
- Minimum press or release width accepted: `DEBOUNCE_CYCLES` cycles at `s2`.
- Width rules:
  - `cnt` saturates by construction (cleared on accept), so it never wraps.
  - The long counter saturates at `LONG_CYCLES`, never wraps.

## Configuration
- `BTN_LONG_PRESS_EN` defined:
  - Per-channel counter, width `$clog2(LONG_CYCLES+1)`, counts while `stb` = 1 and clears when `stb` = 0.
  - On the edge where the count reaches `LONG_CYCLES`, `long_pulse` is high for 1 cycle, once per press, then the counter holds.
  - In toggle mode the same edge forces `led` to 0. In momentary mode `led` is unaffected.
- `BTN_LONG_PRESS_EN` undefined: no counter logic. `long_pulse` is tied to 0 and LED behaviour is as above.

## Test plan
Every scenario uses `N_CH` = 4 and `DEBOUNCE_CYCLES` = 4.
- Reset: assert `rst_n` = 0 mid-simulation with `btn` = 4'hF. `led`, `press_pulse`, `release_pulse`, and `long_pulse` are 0 asynchronously. After release with `btn` held, `press_pulse` fires 6 edges later.
- Toggle: `mode` = 0, ch0 pressed 10 cycles then released, twice.
  - `press_pulse[0]` occurs at edge 6 after each press, and `release_pulse[0]` 6 edges after each release.
  - `led[0]` goes 0 -> 1 -> 0.
- Glitch: ch1 pulses high for 3 cycles, low for 1, and repeats. No pulses occur and `led[1]` stays 0. A final 4-cycle high is accepted.
- Momentary: `mode` = 4'b0100, ch2 held 20 cycles. `led[2]` is high from edge 6 after the press until edge 6 after the release.
- Simultaneous and independent: ch0 and ch3 pressed on the same edge with ch1 idle. Both `press_pulse` bits rise in the same cycle and `press_pulse[1]` = 0.
- With `BTN_LONG_PRESS_EN` and `LONG_CYCLES` = 8, toggle mode, ch0 held 30 cycles:
  - `led[0]` = 1 at edge 6.
  - `long_pulse[0]` is high for exactly 1 cycle 8 cycles after `stb` rises, and `led[0]` = 0 on that edge.
  - Nothing further happens until release.
